// File: rtl/dram_controller_pkg.sv
// Shared definitions for the DRAM initiator controller.
// Holds the FSM state enum, DRAM command pin encodings, default geometry and
// timing constants, and dram_cmd(), which maps a command to RASn/CASn/WEn.
package dram_ctrl_pkg;

  localparam int DRAM_WORD_SIZE = 32;
  localparam int DRAM_ROW_SIZE  = 11;
  localparam int DRAM_COL_SIZE  = 10;

  // Sample-edge spacing, in clock cycles
  localparam int DRAM_T_RP  = 5;
  localparam int DRAM_T_RCD = 5;
  localparam int DRAM_T_CL  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_CAS,
    ST_CAS_WAIT
  } dram_ctrl_state_e;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_PRE,
    CMD_ACT,
    CMD_CAS
  } dram_cmd_e;

  typedef struct packed {
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } dram_pins_t;

  localparam dram_pins_t PINS_NOP = '{rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam dram_pins_t PINS_PRE = '{rasn: 1'b0, casn: 1'b1, wen: 4'h0};
  localparam dram_pins_t PINS_ACT = '{rasn: 1'b0, casn: 1'b1, wen: 4'hF};
  // CAS defaults to a read; a write overrides wen with the inverted strobes
  localparam dram_pins_t PINS_CAS = '{rasn: 1'b1, casn: 1'b0, wen: 4'hF};

  // A write with no strobes still yields wen=F, which the DRAM treats as a read
  function automatic dram_pins_t dram_cmd(dram_cmd_e cmd, logic wr, logic [3:0] wstrb);
    dram_pins_t p;
    case (cmd)
      CMD_PRE: p = PINS_PRE;
      CMD_ACT: p = PINS_ACT;
      CMD_CAS: begin
        p = PINS_CAS;
        if (wr) p.wen = ~wstrb;
      end
      default: p = PINS_NOP;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dram_controller_if.sv
// Request/response bus between the system-bus wrapper and dram_controller.
// Ports (signals):
//   req_valid/req_ready  request handshake
//   req_write            1 = write, 0 = read
//   req_addr             word address, row in the upper bits, column below
//   req_wstrb/req_wdata  byte enables and data for a write
//   rsp_valid            one-cycle completion pulse (reads and writes)
//   rsp_rdata            read data, meaningful with rsp_valid on a read
// Modports: master = bus initiator, slave = controller.
interface dram_controller_if
  import dram_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DRAM_WORD_SIZE,
  parameter int ROW_SIZE  = DRAM_ROW_SIZE,
  parameter int COL_SIZE  = DRAM_COL_SIZE
);

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ROW_SIZE+COL_SIZE-1:0] req_addr;
  logic [3:0]                   req_wstrb;
  logic [WORD_SIZE-1:0]         req_wdata;
  logic                         rsp_valid;
  logic [WORD_SIZE-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wstrb, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wstrb, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dram_controller.sv
// Open-page DRAM initiator controller.
// Accepts single-word requests on the bus interface and issues
// PRE/ACT/CAS sequences on the DRAM pins, keeping the last row open.
// Ports:
//   CK, RSTn          clock, async active-low reset (DRAM.RST = ~RSTn at top)
//   bus (slave)       request/response handshake
//   CSn RASn CASn WEn registered DRAM command pins
//   A, D              registered DRAM address and write data
//   Q, VALID          DRAM read data and its valid flag
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a request, CSn high
// PRE      | precharge of the open row is on the pins
// PRE_WAIT | NOPs until T_RP from the PRE sample edge
// ACT      | activate of the requested row is on the pins
// ACT_WAIT | NOPs until T_RCD from the ACT sample edge
// CAS      | column read/write is on the pins
// CAS_WAIT | NOPs until completion; read data captured on exit
module dram_controller
  import dram_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DRAM_WORD_SIZE,
  parameter int ROW_SIZE  = DRAM_ROW_SIZE,
  parameter int COL_SIZE  = DRAM_COL_SIZE,
  parameter int ADDR_SIZE = (ROW_SIZE > COL_SIZE) ? ROW_SIZE : COL_SIZE,
  parameter int T_RP      = DRAM_T_RP,
  parameter int T_RCD     = DRAM_T_RCD,
  parameter int T_CL      = DRAM_T_CL
) (
  input  logic                 CK,
  input  logic                 RSTn,
  dram_controller_if.slave     bus,
  output logic                 CSn,
  output logic                 RASn,
  output logic                 CASn,
  output logic [3:0]           WEn,
  output logic [ADDR_SIZE-1:0] A,
  output logic [WORD_SIZE-1:0] D,
  input  logic [WORD_SIZE-1:0] Q,
  input  logic                 VALID
);

  // A wait state is entered one edge after its command is registered and
  // leaves when the counter hits zero, so it lasts load+1 cycles. A command
  // registered at edge e is sampled at e+1, hence the -2 for T_RP/T_RCD.
  // A read stays one cycle longer than a write: its data is captured T_CL
  // after the CAS sample edge, whereas a write is done once the next CAS
  // (issued earliest on the accept edge after rsp_valid) respects T_CL.
  localparam logic [2:0] CNT_RP    = 3'(T_RP - 2);
  localparam logic [2:0] CNT_RCD   = 3'(T_RCD - 2);
  localparam logic [2:0] CNT_CL_WR = 3'(T_CL - 2);
  localparam logic [2:0] CNT_CL_RD = 3'(T_CL - 1);

  dram_ctrl_state_e state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;

  logic                write_q;
  logic [3:0]          wstrb_q;
  logic [ROW_SIZE-1:0] row_q;
  logic [COL_SIZE-1:0] col_q;
  logic                row_open_q;
  logic [ROW_SIZE-1:0] open_row_q;

  logic [ROW_SIZE-1:0] req_row;
  logic [COL_SIZE-1:0] req_col;
  logic                in_idle;
  logic                accept;
  logic                cur_write;
  logic [3:0]          cur_wstrb;
  logic [ROW_SIZE-1:0] cur_row;

  dram_cmd_e           cmd_d;
  dram_pins_t          pins_d;
  logic [ADDR_SIZE-1:0] a_d;
  logic                csn_d;
  logic                set_open;
  logic                rsp_d;
  logic                capture;

  assign req_row = bus.req_addr[ROW_SIZE+COL_SIZE-1:COL_SIZE];
  assign req_col = bus.req_addr[COL_SIZE-1:0];
  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle && bus.req_valid;

  // Gating with RSTn keeps ready low for the whole reset assertion
  assign bus.req_ready = RSTn && in_idle;

  // In IDLE the command is built straight from the bus; later from the latch
  assign cur_write = in_idle ? bus.req_write : write_q;
  assign cur_wstrb = in_idle ? bus.req_wstrb : wstrb_q;
  assign cur_row   = in_idle ? req_row       : row_q;

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = CMD_NOP;
    a_d      = A;
    csn_d    = CSn;
    set_open = 1'b0;
    rsp_d    = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        csn_d = 1'b1;
        if (bus.req_valid) begin
          csn_d = 1'b0;
          if (!row_open_q) begin
            state_d  = ST_ACT;
            cmd_d    = CMD_ACT;
            a_d      = ADDR_SIZE'(req_row);
            set_open = 1'b1;
          end else if (req_row != open_row_q) begin
            state_d = ST_PRE;
            cmd_d   = CMD_PRE;
            a_d     = ADDR_SIZE'(open_row_q);
          end else begin
            state_d = ST_CAS;
            cmd_d   = CMD_CAS;
            a_d     = ADDR_SIZE'(req_col);
          end
        end
      end
      ST_PRE: begin
        state_d = ST_PRE_WAIT;
        cnt_d   = CNT_RP;
      end
      ST_PRE_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d  = ST_ACT;
          cmd_d    = CMD_ACT;
          a_d      = ADDR_SIZE'(row_q);
          set_open = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ACT: begin
        state_d = ST_ACT_WAIT;
        cnt_d   = CNT_RCD;
      end
      ST_ACT_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_CAS;
          cmd_d   = CMD_CAS;
          a_d     = ADDR_SIZE'(col_q);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_CAS: begin
        state_d = ST_CAS_WAIT;
        cnt_d   = write_q ? CNT_CL_WR : CNT_CL_RD;
      end
      ST_CAS_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
          rsp_d   = 1'b1;
          capture = !write_q;
          csn_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pins_d = dram_cmd(cmd_d, cur_write, cur_wstrb);
  end

  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      CSn           <= 1'b1;
      {RASn, CASn, WEn} <= PINS_NOP;
      A             <= '0;
      D             <= '0;
      write_q       <= 1'b0;
      wstrb_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      row_open_q    <= 1'b0;
      open_row_q    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      CSn               <= csn_d;
      {RASn, CASn, WEn} <= pins_d;
      A                 <= a_d;
      bus.rsp_valid     <= rsp_d;
      if (accept) begin
        write_q <= bus.req_write;
        wstrb_q <= bus.req_wstrb;
        row_q   <= req_row;
        col_q   <= req_col;
        D       <= bus.req_wdata;
      end
      if (set_open) begin
        row_open_q <= 1'b1;
        open_row_q <= cur_row;
      end
      if (capture) bus.rsp_rdata <= Q;
    end
  end

  // The DRAM must present its data exactly on the capture edge
  read_valid_at_capture: assert property (@(posedge CK) disable iff (!RSTn) capture |-> VALID);

endmodule

// File: tb/tb_dram_controller.sv
module tb_dram_controller;

  localparam int WORD_SIZE = 32;
  localparam int ROW_SIZE  = 11;
  localparam int COL_SIZE  = 10;
  localparam int ADDR_SIZE = 11;
  localparam int T_RP      = 5;
  localparam int T_RCD     = 5;
  localparam int T_CL      = 5;

  logic                 CK = 1'b0;
  logic                 RSTn = 1'b0;
  logic                 CSn, RASn, CASn;
  logic [3:0]           WEn;
  logic [ADDR_SIZE-1:0] A;
  logic [WORD_SIZE-1:0] D;
  logic [WORD_SIZE-1:0] Q = '0;
  logic                 VALID = 1'b0;

  dram_controller_if #(.WORD_SIZE(WORD_SIZE), .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE)) bus ();

  dram_controller #(
    .WORD_SIZE(WORD_SIZE), .ROW_SIZE(ROW_SIZE), .COL_SIZE(COL_SIZE), .ADDR_SIZE(ADDR_SIZE),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL)
  ) dut (
    .CK(CK), .RSTn(RSTn), .bus(bus),
    .CSn(CSn), .RASn(RASn), .CASn(CASn), .WEn(WEn), .A(A), .D(D),
    .Q(Q), .VALID(VALID)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- DRAM stand-in: one bank, rule checks, read pipeline ----
  typedef struct { int kind; int a; int wen; int edge_no; } cmd_t;   // kind 1=PRE 2=ACT 3=CAS
  typedef struct { int edge_no; bit [31:0] data; } rd_t;

  cmd_t      cmd_log[$];
  rd_t       rd_q[$];
  bit [31:0] dram_mem[int];
  bit        bank_open = 0;
  int        bank_row = 0;
  int        last_pre = -100, last_act = -100, last_cas = -100;
  int        viol = 0;
  int        se;
  int        daddr;
  bit [31:0] dword;
  cmd_t      c;

  // Pins seen between edge k and k+1 are what the DRAM samples at edge k+1
  always @(negedge CK) begin
    se = cyc + 1;
    if (!RSTn) begin
      bank_open = 0;
      rd_q.delete();
      last_pre = -100; last_act = -100; last_cas = -100;
      VALID = 1'b0;
    end else begin
      if (!CSn) begin
        c = '{0, int'(A), int'(WEn), se};
        if (!RASn && CASn && WEn == 4'h0) begin
          c.kind = 1;
          bank_open = 0;
          last_pre = se;
          cmd_log.push_back(c);
        end else if (!RASn && CASn && WEn == 4'hF) begin
          c.kind = 2;
          if (bank_open || se - last_pre < T_RP) viol++;
          bank_open = 1;
          bank_row = int'(A);
          last_act = se;
          cmd_log.push_back(c);
        end else if (RASn && !CASn) begin
          c.kind = 3;
          if (!bank_open || se - last_act < T_RCD || se - last_cas < T_CL) viol++;
          last_cas = se;
          daddr = bank_row * 1024 + (int'(A) & 1023);
          dword = dram_mem.exists(daddr) ? dram_mem[daddr] : 32'h0;
          if (WEn == 4'hF) rd_q.push_back('{se + T_CL, dword});
          else begin
            for (int b = 0; b < 4; b++) if (!WEn[b]) dword[8*b +: 8] = D[8*b +: 8];
            dram_mem[daddr] = dword;
          end
          cmd_log.push_back(c);
        end else if (!(RASn && CASn)) viol++;
      end
      VALID = 1'b0;
      if (rd_q.size() > 0 && rd_q[0].edge_no == se) begin
        Q = rd_q[0].data;
        VALID = 1'b1;
        void'(rd_q.pop_front());
      end
    end
  end

  // ---------------- reference model: word memory + open-row rule ----------
  bit        ref_open = 0;
  int        ref_row = 0;
  bit [31:0] ref_mem[int];

  function automatic bit [31:0] ref_get(input int addr);
    return ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
  endfunction

  task automatic check_rst_vals();
    check("rst_csn", CSn, 1);
    check("rst_rasn", RASn, 1);
    check("rst_casn", CASn, 1);
    check("rst_wen", WEn, 4'hF);
    check("rst_a", A, 0);
    check("rst_d", D, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
  endtask

  task automatic check_idle();
    check("idle_ready", bus.req_ready, 1);
    check("idle_csn", CSn, 1);
    check("idle_rsp", bus.rsp_valid, 0);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input bit wr, input int addr, input bit [3:0] strb,
                       input bit [31:0] wd, output int e0);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge CK); n++; end
    check("ready_before_req", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = 21'(addr);
    bus.req_wstrb = strb;
    bus.req_wdata = wd;
    @(negedge CK);
    e0 = cyc;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
  endtask

  task automatic do_req(input bit wr, input int addr, input bit [3:0] strb, input bit [31:0] wd);
    int   e0, t, row, col, kind, exp_lat, n, v0;
    bit   seen;
    bit [3:0]  nstrb;
    bit [31:0] merged;
    cmd_t exp_q[$];
    row = addr >> COL_SIZE;
    col = addr & 1023;
    nstrb = ~strb;
    kind = !ref_open ? 1 : (ref_row != row ? 2 : 0);
    cmd_log.delete();
    v0 = viol;
    issue(wr, addr, strb, wd, e0);
    t = e0 + 1;
    if (kind == 2) begin exp_q.push_back('{1, ref_row, 0, t}); t += T_RP; end
    if (kind != 0) begin exp_q.push_back('{2, row, 0, t}); t += T_RCD; end
    exp_q.push_back('{3, col, wr ? int'(nstrb) : 15, t});
    exp_lat = t - e0 + T_CL - (wr ? 1 : 0);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      if (bus.rsp_valid === 1'b1) seen = 1;
      else begin
        check("busy_csn", CSn, 0);
        check("busy_ready", bus.req_ready, 0);
        @(negedge CK);
        n++;
      end
    end
    check("rsp_seen", seen, 1);
    if (seen) begin
      check("latency", cyc - e0, exp_lat);
      check("ready_with_rsp", bus.req_ready, 1);
      check("csn_at_rsp", CSn, 1);
      if (!wr) check("rdata", bus.rsp_rdata, ref_get(addr));
      check("cmd_count", cmd_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
        check("cmd_kind", cmd_log[i].kind, exp_q[i].kind);
        check("cmd_addr", cmd_log[i].a, exp_q[i].a);
        check("cmd_edge", cmd_log[i].edge_no - e0, exp_q[i].edge_no - e0);
        if (exp_q[i].kind == 3) check("cas_wen", cmd_log[i].wen, exp_q[i].wen);
      end
      check("dram_rules", viol - v0, 0);
    end
    ref_open = 1;
    ref_row = row;
    if (wr) begin
      merged = ref_get(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = wd[8*b +: 8];
      ref_mem[addr] = merged;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, row, col, gap;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wstrb = '0;
    bus.req_wdata = '0;
    RSTn = 1'b0;
    repeat (3) @(negedge CK);
    check_rst_vals();
    RSTn = 1'b1;
    @(negedge CK);
    check_idle();

    do_req(0, 'h00005, 4'h0, 32'h0);                  // no open row: ACT, CAS
    do_req(1, 'h00005, 4'hF, 32'hDEADBEEF);           // row hit write
    do_req(0, 'h00005, 4'h0, 32'h0);                  // row hit read
    do_req(1, 'h00005, 4'b0010, 32'h0000AA00);        // single byte lane
    do_req(0, 'h00005, 4'h0, 32'h0);                  // expects DEADAAEF
    do_req(0, 'h00C05, 4'h0, 32'h0);                  // row miss: PRE row 0, ACT row 3
    do_req(1, 'h00C05, 4'h0, 32'h12345678);           // zero strobes: no data change
    do_req(0, 'h00C05, 4'h0, 32'h0);

    // Reset while in ACT_WAIT of a row-miss read
    issue(0, 'h01C05, 4'h0, 32'h0, e0);
    while (cyc < e0 + T_RP + 2) @(negedge CK);
    RSTn = 1'b0;
    #1;
    check_rst_vals();
    ref_open = 0;
    repeat (2) @(negedge CK);
    check("rsp_in_reset", bus.rsp_valid, 0);
    RSTn = 1'b1;
    @(negedge CK);
    check_idle();
    do_req(0, 'h00C05, 4'h0, 32'h0);                  // ACT without PRE

    for (int i = 0; i < 80; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge CK);
        check_idle();
      end
      row = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 2047) : $urandom_range(0, 3);
      col = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 7);
      do_req(1'($urandom_range(0, 1)), row * 1024 + col, 4'($urandom_range(0, 15)), $urandom);
    end

    @(negedge CK);
    check_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
